fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 132 +++++++++++++
 tb/tb_fetch_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: walks the program counter through an external ROM,
// follows jumps/branches, stops on HALT and counts retired instructions.
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'd0,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic [3:0]       opcode,
    input  logic [15:0]      jmp_loc,
    input  logic             branch_taken,
    output logic [15:0]      pc,
    output logic             valid,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [3:0] OP_JMP  = 4'b0010;
    localparam logic [3:0] OP_BNE  = 4'b1010;
    localparam logic [3:0] OP_BEQ  = 4'b1011;
    localparam logic [3:0] OP_BLT  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1110;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_t           state_r;
    logic [15:0]      pc_r;
    logic             valid_r;
    logic             halted_r;
    logic [CNT_W-1:0] retired_r;
    logic [15:0]      next_pc_s;
    logic [CNT_W-1:0] retired_inc_s;

    // Next-pc selection for a non-stalled RUN cycle (HALT is handled in the FSM).
    always_comb begin
        next_pc_s = pc_r + 16'd1;
        case (opcode)
            OP_JMP: begin
                next_pc_s = jmp_loc;
            end
            OP_BNE, OP_BEQ, OP_BLT: begin
                if (branch_taken) begin
                    next_pc_s = jmp_loc;
                end else begin
                    next_pc_s = pc_r + 16'd1;
                end
            end
            default: begin
                next_pc_s = pc_r + 16'd1;
            end
        endcase
    end

    // Saturating increment of the retired-instruction counter.
    always_comb begin
        if (retired_r == CNT_MAX) begin
            retired_inc_s = retired_r;
        end else begin
            retired_inc_s = retired_r + CNT_ONE;
        end
    end

    // Control FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            pc_r      <= RESET_PC;
            valid_r   <= 1'b0;
            halted_r  <= 1'b0;
            retired_r <= CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    pc_r     <= RESET_PC;
                    halted_r <= 1'b0;
                    if (start) begin
                        state_r   <= RUN;
                        valid_r   <= 1'b1;
                        retired_r <= CNT_ZERO;
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                RUN: begin
                    // A stalled HALT waits here until the stall drops.
                    if (!stall) begin
                        if (opcode == OP_HALT) begin
                            state_r  <= HALT;
                            valid_r  <= 1'b0;
                            halted_r <= 1'b1;
                        end else begin
                            pc_r      <= next_pc_s;
                            retired_r <= retired_inc_s;
                        end
                    end
                end
                HALT: begin
                    if (start) begin
                        state_r   <= RUN;
                        pc_r      <= RESET_PC;
                        retired_r <= CNT_ZERO;
                        halted_r  <= 1'b0;
                        valid_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    pc_r      <= RESET_PC;
                    valid_r   <= 1'b0;
                    halted_r  <= 1'b0;
                    retired_r <= CNT_ZERO;
                end
            endcase
        end
    end

    assign pc      = pc_r;
    assign valid   = valid_r;
    assign halted  = halted_r;
    assign retired = retired_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random traffic,
// all compared against an abstract program-execution model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic [15:0] jmp_loc = 16'd0;
    logic        branch_taken = 1'b0;
    logic [15:0] pc, pc4;
    logic        valid, valid4, halted, halted4;
    logic [15:0] retired;
    logic [3:0]  retired4;

    int total = 0;
    int bad = 0;

    // model: running / halted flags, program counter, unbounded retire count
    bit          m_run = 1'b0;
    bit          m_halt = 1'b0;
    logic [15:0] m_pc = 16'd0;
    int          m_ret = 0;

    fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .opcode(opcode),
        .jmp_loc(jmp_loc), .branch_taken(branch_taken),
        .pc(pc), .valid(valid), .halted(halted), .retired(retired)
    );

    fetch_ctrl #(.RESET_PC(16'd0), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .opcode(opcode),
        .jmp_loc(jmp_loc), .branch_taken(branch_taken),
        .pc(pc4), .valid(valid4), .halted(halted4), .retired(retired4)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_run  = 1'b0;
        m_halt = 1'b0;
        m_pc   = 16'd0;
        m_ret  = 0;
    endtask

    task automatic model_step();
        if (m_halt || !m_run) begin
            if (start) begin
                m_run  = 1'b1;
                m_halt = 1'b0;
                m_pc   = 16'd0;
                m_ret  = 0;
            end
        end else if (!stall) begin
            if (opcode == 4'd14) begin
                m_run  = 1'b0;
                m_halt = 1'b1;
            end else begin
                m_ret = m_ret + 1;
                if (opcode == 4'd2 ||
                    ((opcode == 4'd10 || opcode == 4'd11 || opcode == 4'd12) && branch_taken))
                    m_pc = jmp_loc;
                else
                    m_pc = 16'((32'(m_pc) + 1) % 65536);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] e16;
        logic [3:0]  e4;
        e16 = (m_ret > 65535) ? 16'hFFFF : 16'(m_ret);
        e4  = (m_ret > 15) ? 4'hF : 4'(m_ret);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".valid"}, {15'd0, valid}, {15'd0, m_run});
        chk({tag, ".halted"}, {15'd0, halted}, {15'd0, m_halt});
        chk({tag, ".retired"}, retired, e16);
        chk({tag, ".pc4"}, pc4, m_pc);
        chk({tag, ".retired4"}, {12'd0, retired4}, {12'd0, e4});
    endtask

    task automatic cycle(input string tag, input logic s, input logic st, input logic [3:0] op,
                         input logic [15:0] jl, input logic bt);
        start = s; stall = st; opcode = op; jmp_loc = jl; branch_taken = bt;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    // pull reset low between edges, check immediately, release before the next edge
    task automatic async_reset(input string tag, input logic s_on_release);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        start = s_on_release;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] op;
        #2;
        check_all("reset");
        chk("reset.retired_zero", retired, 16'd0);
        rst_n = 1'b1;
        cycle("idle", 1'b0, 1'b1, 4'd2, 16'd55, 1'b1);

        // sequential fetch
        cycle("start", 1'b1, 1'b0, 4'd7, 16'd0, 1'b0);
        for (int i = 0; i < 5; i++) cycle("seq", 1'b0, 1'b0, 4'd7, 16'd99, 1'b1);
        chk("seq.pc5", pc, 16'd5);
        chk("seq.ret5", retired, 16'd5);

        // jump and branch from pc=3
        async_reset("rst1", 1'b1);
        cycle("start2", 1'b1, 1'b0, 4'd7, 16'd0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("add", 1'b0, 1'b0, 4'd7, 16'd0, 1'b0);
        cycle("jmp", 1'b0, 1'b0, 4'd2, 16'd10, 1'b0);
        chk("jmp.pc10", pc, 16'd10);
        cycle("bne_nt", 1'b0, 1'b0, 4'd10, 16'd40, 1'b0);
        chk("bne.pc11", pc, 16'd11);
        cycle("beq_t", 1'b0, 1'b0, 4'd11, 16'd10, 1'b1);
        chk("beq.pc10", pc, 16'd10);
        cycle("add_bt", 1'b0, 1'b0, 4'd7, 16'd500, 1'b1);
        cycle("self_jmp", 1'b0, 1'b0, 4'd2, 16'd11, 1'b0);
        chk("self.pc11", pc, 16'd11);

        // run to pc=28 and halt
        for (int i = 0; i < 17; i++) cycle("add", 1'b0, 1'b0, 4'd3, 16'd0, 1'b0);
        chk("pre_halt.pc28", pc, 16'd28);
        cycle("halt", 1'b0, 1'b0, 4'd14, 16'd0, 1'b0);
        chk("halt.pc", pc, 16'd28);
        chk("halt.flag", {15'd0, halted}, 16'd1);
        for (int i = 0; i < 3; i++) cycle("halt_hold", 1'b0, 1'b1, 4'bxxxx, 16'hxxxx, 1'bx);
        cycle("restart", 1'b1, 1'b0, 4'bxxxx, 16'hxxxx, 1'bx);
        chk("restart.pc", pc, 16'd0);
        chk("restart.ret", retired, 16'd0);

        // stalled HALT at pc=7
        for (int i = 0; i < 7; i++) cycle("add", 1'b1, 1'b0, 4'd7, 16'd0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("stall_halt", 1'b0, 1'b1, 4'd14, 16'd0, 1'b1);
        chk("stall.pc7", pc, 16'd7);
        chk("stall.ret7", retired, 16'd7);
        cycle("unstall_halt", 1'b0, 1'b0, 4'd14, 16'd0, 1'b0);
        chk("unstall.halted", {15'd0, halted}, 16'd1);

        // wrap from 16'hFFFF
        cycle("restart2", 1'b1, 1'b0, 4'd7, 16'd0, 1'b0);
        cycle("jmp_top", 1'b0, 1'b0, 4'd2, 16'hFFFF, 1'b0);
        cycle("wrap", 1'b0, 1'b0, 4'd1, 16'd0, 1'b0);
        chk("wrap.pc", pc, 16'h0000);
        chk("wrap.valid", {15'd0, valid}, 16'd1);

        // saturation of the narrow counter
        for (int i = 0; i < 20; i++) cycle("sat", 1'b0, 1'b0, 4'd7, 16'd0, 1'b0);
        chk("sat.ret4", {12'd0, retired4}, 16'h000F);

        // async reset mid-RUN at pc=9, start honoured on the release edge
        async_reset("rst2", 1'b1);
        cycle("start3", 1'b1, 1'b0, 4'd7, 16'd0, 1'b0);
        for (int i = 0; i < 9; i++) cycle("add", 1'b0, 1'b0, 4'd7, 16'd0, 1'b0);
        chk("pre_rst.pc9", pc, 16'd9);
        async_reset("rst_mid_run", 1'b1);
        cycle("rel_start", 1'b1, 1'b0, 4'd7, 16'd0, 1'b0);
        chk("rel_start.valid", {15'd0, valid}, 16'd1);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                async_reset("rnd_rst", 1'($urandom_range(0, 1)));
            end
            op = 4'($urandom_range(0, 15));
            if (op == 4'd14 && $urandom_range(0, 3) != 0) op = 4'd7;
            if (m_run)
                cycle("rnd", 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0), op,
                      16'($urandom), 1'($urandom_range(0, 1)));
            else
                cycle("rnd_idle", 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                      4'bxxxx, 16'hxxxx, 1'bx);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
